can_tx_mailbox: RTL and testbench

- Transmit-side message buffer sitting directly upstream of a CAN node.
- Accepts {ID, payload} messages from the host side and queues them.
- Supplies the head message to the node as In_packet/Tx_ID when the node raises data_in_req.
- Holds each message until the node reports success, or until a bounded number of failed attempts have occurred, then drops it.

---
 rtl/can_tx_mailbox_if.sv | 34 +++
 rtl/can_tx_mailbox.sv | 108 ++++++++++
 tb/tb_can_tx_mailbox.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/can_tx_mailbox_if.sv
// rtl/can_tx_mailbox_if.sv - host write and CAN node transmit handshakes for can_tx_mailbox
// Signals:
//   wr_valid/wr_ready/wr_data/wr_id   - host offers {ID, payload}; accepted when both valid and ready
//   data_in_req                       - node asks for the next message (level)
//   In_packet/Tx_ID/pkt_valid         - message currently handed to the node
//   tx_done/tx_error                  - one-cycle result pulses from the node
//   drop                              - one-cycle pulse when the head message is discarded
// Modports: master = host/node side, slave = mailbox.
interface can_tx_mailbox_if #(
  parameter int DATA_SIZE = 64,
  parameter int ID_SIZE   = 11
);
  logic                 wr_valid;
  logic                 wr_ready;
  logic [DATA_SIZE-1:0] wr_data;
  logic [ID_SIZE-1:0]   wr_id;
  logic                 data_in_req;
  logic [DATA_SIZE-1:0] In_packet;
  logic [ID_SIZE-1:0]   Tx_ID;
  logic                 pkt_valid;
  logic                 tx_done;
  logic                 tx_error;
  logic                 drop;

  modport master (
    output wr_valid, wr_data, wr_id, data_in_req, tx_done, tx_error,
    input  wr_ready, In_packet, Tx_ID, pkt_valid, drop
  );

  modport slave (
    input  wr_valid, wr_data, wr_id, data_in_req, tx_done, tx_error,
    output wr_ready, In_packet, Tx_ID, pkt_valid, drop
  );
endinterface

// File: rtl/can_tx_mailbox.sv
// rtl/can_tx_mailbox.sv - CAN transmit mailbox: queue of {ID, payload} with bounded retry and drop
// Ports:
//   clock        - rising-edge clock
//   reset        - asynchronous active-low reset
//   bus (slave)  - host write handshake and node transmit handshake (see can_tx_mailbox_if)
//   count        - queued entries, including the one in flight
//   full, empty  - count == DEPTH, count == 0
module can_tx_mailbox #(
  parameter int DATA_SIZE = 64,
  parameter int ID_SIZE   = 11,
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  can_tx_mailbox_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] IN_FLIGHT = 1'b1;

  logic [0:0]           state;
  logic [DATA_SIZE-1:0] mem_data [DEPTH];
  logic [ID_SIZE-1:0]   mem_id   [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [RW-1:0]        retry_cnt;
  logic                 wr_fire;
  logic                 launch;
  logic                 give_up;
  logic                 pop;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign bus.wr_ready = !full;
  assign wr_fire      = bus.wr_valid && !full;
  assign launch       = (state == IDLE) && bus.data_in_req && !empty;

  // tx_done has priority: an error in the same cycle as a success is not a failure.
  assign give_up = (state == IN_FLIGHT) && !bus.tx_done && bus.tx_error &&
                   (retry_cnt == RETRY_LAST);
  assign pop     = ((state == IN_FLIGHT) && bus.tx_done) || give_up;

  // Storage is deliberately left out of reset; only pointers and count define validity.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      mem_data[wr_ptr] <= bus.wr_data;
      mem_id[wr_ptr]   <= bus.wr_id;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      retry_cnt     <= '0;
      bus.In_packet <= '0;
      bus.Tx_ID     <= '0;
      bus.pkt_valid <= 1'b0;
      bus.drop      <= 1'b0;
    end else begin
      bus.drop <= give_up;

      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);

      // The in-flight entry keeps its slot until it completes, so count only moves on pop.
      case ({wr_fire, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (launch) begin
            bus.In_packet <= mem_data[rd_ptr];
            bus.Tx_ID     <= mem_id[rd_ptr];
            bus.pkt_valid <= 1'b1;
            retry_cnt     <= '0;
            state         <= IN_FLIGHT;
          end
        end
        IN_FLIGHT: begin
          // In_packet/Tx_ID are left untouched so the node re-arbitrates the same frame.
          if (pop) begin
            bus.pkt_valid <= 1'b0;
            state         <= IDLE;
          end else if (bus.tx_error) begin
            retry_cnt <= retry_cnt + RW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_can_tx_mailbox.sv
// tb/tb_can_tx_mailbox.sv - self-checking bench for can_tx_mailbox against a queue-based reference model
module tb_can_tx_mailbox;
  localparam int DATA_SIZE = 64;
  localparam int ID_SIZE   = 11;
  localparam int DEPTH     = 4;
  localparam int MAX_RETRY = 3;
  localparam int CW        = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  can_tx_mailbox_if #(.DATA_SIZE(DATA_SIZE), .ID_SIZE(ID_SIZE)) bus ();

  can_tx_mailbox #(
    .DATA_SIZE(DATA_SIZE), .ID_SIZE(ID_SIZE), .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave),
    .count(count),
    .full (full),
    .empty(empty)
  );

  always #5 clock = ~clock;

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  // Reference model: a queue of whole messages, head = in-flight one.
  logic [ID_SIZE+DATA_SIZE-1:0] q[$];
  bit                           m_busy;
  int                           m_tries;
  logic [DATA_SIZE-1:0]         m_pkt;
  logic [ID_SIZE-1:0]           m_id;
  bit                           m_drop;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL [%s] %s: got 0x%0h expected 0x%0h", phase, tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy  = 1'b0;
    m_tries = 0;
    m_pkt   = '0;
    m_id    = '0;
    m_drop  = 1'b0;
  endtask

  task automatic model_step();
    bit pop_now = 1'b0;
    bit room    = (q.size() < DEPTH);
    m_drop = 1'b0;
    if (m_busy) begin
      if (bus.tx_done) begin
        pop_now = 1'b1;
      end else if (bus.tx_error) begin
        m_tries++;
        if (m_tries >= MAX_RETRY) begin
          pop_now = 1'b1;
          m_drop  = 1'b1;
        end
      end
    end else if (bus.data_in_req && q.size() != 0) begin
      m_busy        = 1'b1;
      m_tries       = 0;
      {m_id, m_pkt} = q[0];
    end
    if (pop_now) begin
      void'(q.pop_front());
      m_busy = 1'b0;
    end
    if (bus.wr_valid && room) q.push_back({bus.wr_id, bus.wr_data});
  endtask

  task automatic compare_all();
    check("In_packet", bus.In_packet, m_pkt);
    check("Tx_ID", 64'(bus.Tx_ID), 64'(m_id));
    check("pkt_valid", 64'(bus.pkt_valid), 64'(m_busy));
    check("drop", 64'(bus.drop), 64'(m_drop));
    check("count", 64'(count), 64'(q.size()));
    check("full", 64'(full), 64'(q.size() == DEPTH));
    check("empty", 64'(empty), 64'(q.size() == 0));
    check("wr_ready", 64'(bus.wr_ready), 64'(q.size() != DEPTH));
  endtask

  task automatic drive(input bit wv, input logic [ID_SIZE-1:0] id, input logic [DATA_SIZE-1:0] d,
                       input bit req, input bit done, input bit err);
    bus.wr_valid    = wv;
    bus.wr_id       = id;
    bus.wr_data     = d;
    bus.data_in_req = req;
    bus.tx_done     = done;
    bus.tx_error    = err;
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) model_step();
    #1;
    compare_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (q.size() != 0 || m_busy); i++) begin
      drive(1'b0, '0, '0, 1'b1, m_busy, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check("drained_empty", 64'(empty), 64'd1);
  endtask

  task automatic rand_data(output logic [DATA_SIZE-1:0] d);
    d = {$urandom(), $urandom()};
  endtask

  initial begin
    logic [DATA_SIZE-1:0] d;

    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #1;
    phase = "reset";
    compare_all();
    #21 reset = 1'b1;

    phase = "basic";
    drive(1'b1, 11'h001, 64'hFFFFEEEE0000FEF1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    check("basic_launch_pkt", bus.In_packet, 64'hFFFFEEEE0000FEF1);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    check("basic_done_empty", 64'(empty), 64'd1);

    phase = "full";
    for (int i = 0; i < 5; i++) begin
      rand_data(d);
      drive(1'b1, 11'(12'h100 + i), d, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    check("full_count", 64'(count), 64'd4);
    check("full_flag", 64'(full), 64'd1);
    drain();

    phase = "retry_drop";
    drive(1'b1, 11'h7FF, 64'hAAAABBBBCCCC0020, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int e = 0; e < MAX_RETRY; e++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
      tick();
      if (e < MAX_RETRY - 1)
        check("retry_pkt_stable", bus.In_packet, 64'hAAAABBBBCCCC0020);
      else
        check("drop_pulse", 64'(bus.drop), 64'd1);
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("drop_one_cycle", 64'(bus.drop), 64'd0);

    phase = "priority";
    for (int i = 0; i < 2; i++) begin
      rand_data(d);
      drive(1'b1, 11'(12'h200 + i), d, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    tick();
    check("prio_no_drop", 64'(bus.drop), 64'd0);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int e = 0; e < MAX_RETRY; e++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();

    phase = "wrap";
    for (int i = 0; i < 24; i++) begin
      rand_data(d);
      drive(1'b1, 11'(12'h300 + i), d, 1'b1, m_busy, 1'b0);
      tick();
    end
    drain();

    phase = "reset_mid";
    for (int i = 0; i < 3; i++) begin
      rand_data(d);
      drive(1'b1, 11'(12'h400 + i), d, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    check("pre_reset_valid", 64'(bus.pkt_valid), 64'd1);
    #2 reset = 1'b0;
    #1 model_reset();
    compare_all();
    tick();
    #3 reset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("no_launch_after_reset", 64'(bus.pkt_valid), 64'd0);
    rand_data(d);
    drive(1'b1, 11'h055, d, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    check("launch_after_write", 64'(bus.pkt_valid), 64'd1);
    drain();

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      rand_data(d);
      drive(1'($urandom_range(0, 1)), 11'($urandom()), d,
            1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) == 0));
      tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
